// File: rtl/round_key_reader.sv
// ============================================================================
// round_key_reader
//
// Read-side sequencer for the 15 x 128-bit AES round-key store. On `start`
// it walks the store in ascending (encrypt) or descending (decrypt) order for
// the selected key length, absorbs the store's one-cycle registered read
// latency and streams the keys to the cipher datapath over valid/ready at up
// to one key per cycle.
//
// Handshake: a key is transferred in every cycle where rk_valid & rk_ready
// are both high. Once rk_valid is raised it stays high, and rk_data /
// rk_index / rk_last stay stable, until that transfer happens.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a sequence (sampled only when idle)
//   key_len    in   00=AES-128, 01=AES-192, 10=AES-256, 11=treated as 00
//   decrypt    in   0: addresses 0..Nr, 1: addresses Nr..0
//   abort      in   (only with ROUND_KEY_READER_ABORT_EN) cancel a sequence
//   mem_addr   out  registered key-store read address
//   mem_rdata  in   key-store read data, valid one cycle after mem_addr
//   rk_valid   out  round key available
//   rk_ready   in   consumer accepts the round key
//   rk_data    out  round key
//   rk_index   out  delivery position 0..Nr
//   rk_last    out  high with the final key (rk_index == Nr)
//   busy       out  sequence in progress
//   done       out  one-cycle pulse after the final key is accepted
//
// Build option:
//   ROUND_KEY_READER_ABORT_EN  adds the `abort` input; when undefined a
//                              sequence ends only on completion or reset.
// ============================================================================
module round_key_reader #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic              decrypt,
`ifdef ROUND_KEY_READER_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [DATA_W-1:0] rk_data,
    output logic [3:0]        rk_index,
    output logic              rk_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Number of rounds for a key length; the reserved code falls back to
    // AES-128.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        logic [3:0] nr;
        case (kl)
            2'b01:   nr = 4'd12;
            2'b10:   nr = 4'd14;
            default: nr = 4'd10;
        endcase
        return nr;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              state;
    state_t              next_state;

    logic [3:0]          nr_q;        // latched round count
    logic                dir_q;       // latched direction, 1 = descending
    logic [4:0]          issued;      // reads issued so far (0..15)
    logic                rd_v1;       // mem_addr this cycle is a live read
    logic                rd_v2;       // mem_rdata this cycle is a live key
    logic [3:0]          wr_idx;      // delivery position of next FIFO write
    logic [ADDR_W-1:0]   addr_q;
    logic                done_q;

    // Output FIFO: 4 entries of key + delivery index
    logic [DATA_W-1:0]   fifo_data [4];
    logic [3:0]          fifo_idx  [4];
    logic [1:0]          wr_ptr;
    logic [1:0]          rd_ptr;
    logic [2:0]          count;

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic [1:0]          inflight;
    logic [2:0]          occupancy;
    logic                room;
    logic [4:0]          nr_plus;
    logic                fifo_wr;
    logic                pop;
    logic                head_last;
    logic                issue;
    logic                issue_first;
    logic                finish;
    logic                abort_hit;

    // Issue throttling looks only at registered counts, so rk_ready has no
    // combinational path to mem_addr. Counting in-flight reads as occupied
    // slots guarantees the FIFO cannot overflow.
    assign inflight  = {1'b0, rd_v1} + {1'b0, rd_v2};
    assign occupancy = count + {1'b0, inflight};
    assign room      = (occupancy < 3'd4);
    assign nr_plus   = {1'b0, nr_q} + 5'd1;

    assign fifo_wr   = rd_v2;
    assign pop       = rk_valid & rk_ready;
    assign head_last = (fifo_idx[rd_ptr] == nr_q);

`ifdef ROUND_KEY_READER_ABORT_EN
    // Abort only matters while a sequence is active; in IDLE a coincident
    // start wins.
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle controls
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        issue       = 1'b0;
        issue_first = 1'b0;
        finish      = 1'b0;

        unique case (state)
            S_IDLE: begin
                // The first read goes out on the same edge that accepts
                // start, giving the 3-cycle start-to-key latency.
                if (start) begin
                    issue       = 1'b1;
                    issue_first = 1'b1;
                    next_state  = S_RUN;
                end
            end
            S_RUN: begin
                if ((issued < nr_plus) && room) begin
                    issue = 1'b1;
                    // This read is the Nr+1-th one.
                    if (issued == {1'b0, nr_q}) begin
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Only the final key carries index Nr, so its handshake
                // marks the end of the sequence.
                if (pop && head_last) begin
                    finish     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            next_state  = S_IDLE;
            issue       = 1'b0;
            issue_first = 1'b0;
            finish      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline, counters and FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nr_q    <= 4'd0;
            dir_q   <= 1'b0;
            issued  <= 5'd0;
            rd_v1   <= 1'b0;
            rd_v2   <= 1'b0;
            wr_idx  <= 4'd0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
        end else if (abort_hit) begin
            // Flush everything; reads still in the store pipeline are
            // dropped by clearing their valid bits.
            issued  <= 5'd0;
            rd_v1   <= 1'b0;
            rd_v2   <= 1'b0;
            wr_idx  <= 4'd0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
        end else begin
            done_q <= finish;
            rd_v1  <= issue;
            rd_v2  <= rd_v1;

            if (issue_first) begin
                nr_q   <= nr_of(key_len);
                dir_q  <= decrypt;
                addr_q <= decrypt ? ADDR_W'(nr_of(key_len)) : '0;
                issued <= 5'd1;
            end else if (issue) begin
                addr_q <= dir_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
                issued <= issued + 5'd1;
            end else if (finish) begin
                addr_q <= '0;
            end

            // wr_idx restarts with each sequence; nothing is in flight when
            // a new start is accepted, so the two branches never collide.
            if (issue_first) begin
                wr_idx <= 4'd0;
            end else if (fifo_wr) begin
                wr_idx <= wr_idx + 4'd1;
            end

            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end

            case ({fifo_wr, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_idx[wr_ptr]  <= wr_idx;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr = addr_q;
    assign rk_valid = (count != 3'd0);
    assign rk_data  = rk_valid ? fifo_data[rd_ptr] : '0;
    assign rk_index = rk_valid ? fifo_idx[rd_ptr]  : 4'd0;
    assign rk_last  = rk_valid & head_last;
    assign busy     = (state != S_IDLE);
    assign done     = done_q;

endmodule
